// File: rtl/mipi_pixel_packer.sv
// mipi_pixel_packer: packs RGB888 pixel pairs into flagged 48-bit words behind a FWFT FIFO
// Ports:
//   clk, rst (sync, active-low)
//   red_i/green_i/blue_i, vsync_i, valid_i : pixel stream from the timing generator
//   err_clr                               : clears the sticky error flags
//   tx_data/tx_fs/tx_ls/tx_le/tx_valid     : word and flags toward the packetiser
//   tx_ready                              : packetiser accepts the word
//   fifo_level, overflow, line_len_err     : status
module mipi_pixel_packer #(
  parameter int LINE_PIXELS = 800,
  parameter int FIFO_AW = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         red_i,
  input  logic [7:0]         green_i,
  input  logic [7:0]         blue_i,
  input  logic               vsync_i,
  input  logic               valid_i,
  input  logic               err_clr,
  output logic [47:0]        tx_data,
  output logic               tx_fs,
  output logic               tx_ls,
  output logic               tx_le,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic               line_len_err
);
  typedef enum logic {IDLE, LINE} state_t;
  localparam logic [FIFO_AW:0] L_FULL = (FIFO_AW+1)'(1) << FIFO_AW;
  state_t r_state, w_next;
  logic r_vsync_d, r_fs_armed, r_ls, r_half, r_pend_valid, r_wr_en, r_ovf, r_len_err;
  logic [23:0] r_pix0;
  logic [47:0] r_pend_data;
  logic [15:0] r_cnt;
  logic [50:0] r_wr_data;
  logic [50:0] r_mem [1<<FIFO_AW];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0] r_level;
  logic [23:0] w_pix;
  logic [50:0] w_rd;
  logic w_vs_rise, w_close, w_start, w_take, w_push, w_pop, w_wr;
  assign w_pix = {blue_i, green_i, red_i};
  assign w_vs_rise = vsync_i & ~r_vsync_d;
  // a frame start inside a line ends that line just like valid dropping
  assign w_close = (r_state == LINE) & (~valid_i | w_vs_rise);
  assign w_start = (r_state == IDLE) & valid_i;
  assign w_take = (r_state == LINE) & valid_i & ~w_vs_rise;
  // a pending pair always leaves the next cycle; a lone pixel0 only leaves on close
  assign w_push = r_pend_valid | (w_close & r_half);
  assign w_pop = tx_valid & tx_ready;
  assign w_wr = r_wr_en & ((r_level != L_FULL) | w_pop);
  always_comb begin
    w_next = (r_state == IDLE) ? (valid_i ? LINE : IDLE) : (w_close ? IDLE : LINE);
  end
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    r_vsync_d <= vsync_i;
    if (!rst) begin
      r_fs_armed <= 1'b0;
      r_ls <= 1'b0;
      r_half <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_data <= '0;
      r_pix0 <= '0;
      r_cnt <= '0;
      r_wr_en <= 1'b0;
      r_wr_data <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
      r_ovf <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_fs_armed <= w_vs_rise | (r_fs_armed & ~w_push);
      r_ls <= w_start | (r_ls & ~w_push);
      r_pend_valid <= w_take & r_half;
      r_wr_en <= w_push;
      if (w_push) r_wr_data <= {r_fs_armed, r_ls, w_close, r_pend_valid ? r_pend_data : {24'h0, r_pix0}};
      if (w_start) begin
        r_pix0 <= w_pix;
        r_half <= 1'b1;
        r_cnt <= 16'd1;
      end else if (w_take) begin
        r_half <= ~r_half;
        r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 16'd1;
        if (r_half) r_pend_data <= {w_pix, r_pix0};
        else r_pix0 <= w_pix;
      end else if (w_close) r_half <= 1'b0;
      r_len_err <= (w_close & (r_cnt != 16'(LINE_PIXELS))) | (r_len_err & ~err_clr);
      r_ovf <= (r_wr_en & ~w_wr) | (r_ovf & ~err_clr);
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + (FIFO_AW+1)'(w_wr) - (FIFO_AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_wr_data;
  end
  assign w_rd = r_mem[r_rptr];
  assign tx_valid = r_level != '0;
  assign {tx_fs, tx_ls, tx_le, tx_data} = tx_valid ? w_rd : '0;
  assign fifo_level = r_level;
  assign overflow = r_ovf;
  assign line_len_err = r_len_err;
endmodule
